fir_mac_engine: RTL and testbench

Parametrised, multi-channel, time-multiplexed single-multiplier FIR engine for the equalizer datapath. On each `start` it walks `NUM_TAPS` coefficient/sample pairs from external synchronous-read memories, then emits one rounded output sample tagged with its channel. A pipelined multiply-accumulate with guard bits and configurable output scaling keeps the multiplier off the critical path. It sits between the per-channel sample history buffers / coefficient ROM banks and the band-summing stage.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_mac_engine_if.sv | 30 +++
 rtl/fir_mac_pipe.sv | 67 ++++++
 rtl/fir_mac_engine.sv | 129 ++++++++++++
 tb/tb_fir_mac_engine.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC engine.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fir_state_e;

   localparam int unsigned FIR_DRAIN_CYC = 3;

   // $clog2 that never returns less than 1, for select fields
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Control, memory read and result bus of the FIR MAC engine.
interface fir_mac_engine_if #(
   parameter int unsigned CH_W    = 1,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned COEFF_W = 16
);
   logic                      start;
   logic [CH_W-1:0]           ch_sel;
   logic                      abort;
   logic                      busy;
   logic [CH_W-1:0]           act_ch;
   logic [ADDR_W-1:0]         tap_addr;
   logic signed [DATA_W-1:0]  smpl_in;
   logic signed [COEFF_W-1:0] cff_in;
   logic                      out_valid;
   logic signed [DATA_W-1:0]  out_data;
   logic [CH_W-1:0]           out_ch;
   logic                      sat_flag;

   modport slave (
      input  start, ch_sel, abort, smpl_in, cff_in,
      output busy, act_ch, tap_addr, out_valid, out_data, out_ch, sat_flag
   );

   modport master (
      output start, ch_sel, abort, smpl_in, cff_in,
      input  busy, act_ch, tap_addr, out_valid, out_data, out_ch, sat_flag
   );
endinterface

// File: rtl/fir_mac_pipe.sv
// Product register, 2-stage valid shift, guarded accumulator and round/shift reduction.
// FIR_SAT_EN selects saturating reduction; otherwise the result wraps.
module fir_mac_pipe
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned COEFF_W   = 16,
   parameter int unsigned ACC_W     = 40,
   parameter int unsigned OUT_SHIFT = 15
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_clr,
   input  logic                      i_en,
   input  logic                      i_abort,
   input  logic signed [DATA_W-1:0]  i_smpl,
   input  logic signed [COEFF_W-1:0] i_cff,
   output logic signed [DATA_W-1:0]  o_res_c,
   output logic                      o_sat_c
);
   localparam int unsigned PROD_W = DATA_W + COEFF_W;
   localparam int unsigned SH_W   = ACC_W - OUT_SHIFT;
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (OUT_SHIFT - 1);

   logic [1:0]               r_vld;
   logic signed [PROD_W-1:0] r_prod;
   logic signed [ACC_W-1:0]  r_acc;

   // r_vld[0]: read data valid, r_vld[1]: product valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_prod <= '0;
         r_acc  <= '0;
      end else begin
         if (i_abort || i_clr) r_vld <= '0;
         else                  r_vld <= {r_vld[0], i_en};
         if (r_vld[0]) r_prod <= PROD_W'(i_smpl) * PROD_W'(i_cff);
         if (i_clr)
            r_acc <= '0;
         else if (r_vld[1] && !i_abort)
            r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
      end
   end

`ifdef FIR_SAT_EN
   logic signed [SH_W-1:0]   w_sh;
   logic [SH_W-DATA_W:0]     w_hi;
   logic                     w_ovf;

   assign w_sh  = SH_W'((r_acc + RND) >>> OUT_SHIFT);
   assign w_hi  = w_sh[SH_W-1:DATA_W-1];
   // in range only if the bits above the output sign all equal it
   assign w_ovf = !((&w_hi) || !(|w_hi));

   always_comb begin
      o_res_c = w_sh[DATA_W-1:0];
      if (w_ovf) o_res_c = w_sh[SH_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
   end
   assign o_sat_c = w_ovf;
`else
   assign o_res_c = DATA_W'((r_acc + RND) >>> OUT_SHIFT);
   assign o_sat_c = 1'b0;
`endif

endmodule

// File: rtl/fir_mac_engine.sv
// Multi-channel single-multiplier FIR engine: FSM, tap counter, channel latch, output regs.
// Optional FIR_SAT_EN enables output saturation in the MAC pipe.
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter int unsigned NUM_TAPS  = 1021,
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned COEFF_W   = 16,
   parameter int unsigned ACC_W     = 40,
   parameter int unsigned OUT_SHIFT = 15
)(
   input logic               clk,
   input logic               rst_n,
   fir_mac_engine_if.slave   bus
);
   localparam int unsigned ADDR_W   = $clog2(NUM_TAPS);
   localparam int unsigned CH_W     = clog2_min1(NUM_CH);
   localparam int unsigned DRN_W    = clog2_min1(FIR_DRAIN_CYC);
   localparam int unsigned LAST_TAP = NUM_TAPS - 1;

   fir_state_e               r_state;
   fir_state_e               w_state_nxt;
   logic [ADDR_W-1:0]        r_tap_addr;
   logic [DRN_W-1:0]         r_drn_cnt;
   logic [CH_W-1:0]          r_act_ch;
   logic [CH_W-1:0]          r_out_ch;
   logic signed [DATA_W-1:0] r_out_data;
   logic                     r_out_valid;
   logic                     r_sat;
   logic                     r_busy;
   logic                     w_accept;
   logic                     w_run;
   logic                     w_done;
   logic                     w_abort;
   logic signed [DATA_W-1:0] w_res_c;
   logic                     w_sat_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = RUN;
         RUN:     if (bus.abort) w_state_nxt = IDLE;
                  else if (r_tap_addr == ADDR_W'(LAST_TAP)) w_state_nxt = DRAIN;
         DRAIN:   if (bus.abort || w_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // abort outranks completion on the final drain cycle
   always_comb begin
      w_accept = 1'b0;
      w_run    = 1'b0;
      w_done   = 1'b0;
      w_abort  = 1'b0;
      case (r_state)
         IDLE:    w_accept = bus.start && ({1'b0, bus.ch_sel} < (CH_W+1)'(NUM_CH));
         RUN:     begin
                     w_run   = 1'b1;
                     w_abort = bus.abort;
                  end
         DRAIN:   begin
                     w_abort = bus.abort;
                     w_done  = !bus.abort && (r_drn_cnt == DRN_W'(FIR_DRAIN_CYC - 1));
                  end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tap_addr  <= '0;
         r_drn_cnt   <= '0;
         r_act_ch    <= '0;
         r_out_ch    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_sat       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_busy      <= (w_state_nxt != IDLE);
         r_out_valid <= w_done;
         r_sat       <= w_done && w_sat_c;
         if (w_done) begin
            r_out_data <= w_res_c;
            r_out_ch   <= r_act_ch;
         end
         if (w_accept) begin
            r_act_ch   <= bus.ch_sel;
            r_tap_addr <= '0;
         end else if (w_run && (r_tap_addr != ADDR_W'(LAST_TAP))) begin
            r_tap_addr <= r_tap_addr + ADDR_W'(1);
         end
         if (r_state == DRAIN) r_drn_cnt <= r_drn_cnt + DRN_W'(1);
         else                  r_drn_cnt <= '0;
      end
   end

   fir_mac_pipe #(
      .DATA_W    (DATA_W),
      .COEFF_W   (COEFF_W),
      .ACC_W     (ACC_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_accept),
      .i_en    (w_run),
      .i_abort (w_abort),
      .i_smpl  (bus.smpl_in),
      .i_cff   (bus.cff_in),
      .o_res_c (w_res_c),
      .o_sat_c (w_sat_c)
   );

   assign bus.busy      = r_busy;
   assign bus.act_ch    = r_act_ch;
   assign bus.tap_addr  = r_tap_addr;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;
   assign bus.sat_flag  = r_sat;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine with a registered-read memory model per channel.
module tb_fir_mac_engine;
   localparam int unsigned NUM_TAPS  = 4;
   localparam int unsigned NUM_CH    = 3;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned COEFF_W   = 16;
   localparam int unsigned ACC_W     = 40;
   localparam int unsigned OUT_SHIFT = 15;
   localparam int unsigned ADDR_W    = 2;
   localparam int unsigned CH_W      = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fir_mac_engine_if #(.CH_W(CH_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .COEFF_W(COEFF_W)) bus ();

   fir_mac_engine #(
      .NUM_TAPS(NUM_TAPS), .NUM_CH(NUM_CH), .DATA_W(DATA_W),
      .COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [CH_W-1:0]   ch;
      logic              sat;
      int                cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic signed [DATA_W-1:0]  smem [4][4];
   logic signed [COEFF_W-1:0] cmem [4][4];

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous-read sample and coefficient banks
   always @(posedge clk) begin
      bus.smpl_in <= smem[bus.act_ch][bus.tap_addr];
      bus.cff_in  <= cmem[bus.act_ch][bus.tap_addr];
   end

   function automatic exp_t model(input int ch, input int c0);
      longint acc = 0;
      longint r;
      exp_t   e;
      for (int k = 0; k < NUM_TAPS; k++)
         acc += longint'(smem[ch][k]) * longint'(cmem[ch][k]);
      r = (acc + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
      e.sat = 1'b0;
`ifdef FIR_SAT_EN
      if (r > (longint'(1) <<< (DATA_W - 1)) - 1) begin
         r = (longint'(1) <<< (DATA_W - 1)) - 1;
         e.sat = 1'b1;
      end else if (r < -(longint'(1) <<< (DATA_W - 1))) begin
         r = -(longint'(1) <<< (DATA_W - 1));
         e.sat = 1'b1;
      end
`endif
      e.data = r[DATA_W-1:0];
      e.ch   = ch[CH_W-1:0];
      e.cyc  = c0 + NUM_TAPS + 4;
      return e;
   endfunction

   // output monitor: pops the scoreboard on every result strobe
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL out_valid_unexpected: out_valid=1 at cycle %0d, required no result", cyc);
            end else begin
               mon_e = sb.pop_front();
               checks++;
               if (bus.out_data !== mon_e.data) begin
                  failures++;
                  $display("FAIL out_data: got %h, required %h", bus.out_data, mon_e.data);
               end
               checks++;
               if (bus.out_ch !== mon_e.ch) begin
                  failures++;
                  $display("FAIL out_ch: got %0d, required %0d", bus.out_ch, mon_e.ch);
               end
               checks++;
               if (bus.sat_flag !== mon_e.sat) begin
                  failures++;
                  $display("FAIL sat_flag: got %b, required %b", bus.sat_flag, mon_e.sat);
               end
               checks++;
               if (cyc !== mon_e.cyc) begin
                  failures++;
                  $display("FAIL latency: out_valid at cycle %0d, required %0d", cyc, mon_e.cyc);
               end
               checks++;
               if (bus.busy !== 1'b0) begin
                  failures++;
                  $display("FAIL busy_at_out_valid: got %b, required 0", bus.busy);
               end
            end
         end else begin
            checks++;
            if (bus.sat_flag !== 1'b0) begin
               failures++;
               $display("FAIL sat_flag_idle: got %b, required 0", bus.sat_flag);
            end
         end
      end
   end

   task automatic launch(input int ch, input bit push);
      bus.ch_sel = CH_W'(ch);
      bus.start  = 1'b1;
      if (push) sb.push_back(model(ch, cyc));
      @(negedge clk);
      bus.start  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && (sb.size() != 0 || bus.busy !== 1'b0); i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.ch_sel = '0; bus.abort = 1'b0;
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 4; k++) begin
            smem[c][k] = '0;
            cmem[c][k] = '0;
         end
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.out_valid, bus.sat_flag} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: busy/out_valid/sat=%b, required 000", {bus.busy, bus.out_valid, bus.sat_flag});
      end
      checks++;
      if (bus.tap_addr !== '0 || bus.act_ch !== '0 || bus.out_ch !== '0 || bus.out_data !== '0) begin
         failures++;
         $display("FAIL reset_regs: tap=%0d act=%0d och=%0d od=%h, required all 0",
                  bus.tap_addr, bus.act_ch, bus.out_ch, bus.out_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      // reset in the middle of a pass
      smem[1][0] = 16'sd5; cmem[1][0] = 16'sd7;
      launch(1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.tap_addr !== '0 || bus.act_ch !== '0) begin
         failures++;
         $display("FAIL reset_midrun: busy=%b tap=%0d act=%0d, required 0 0 0", bus.busy, bus.tap_addr, bus.act_ch);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_output: out_valid=%b, required 0", bus.out_valid);
         end
      end
   endtask

   task automatic test_impulse();
      for (int k = 0; k < NUM_TAPS; k++) begin
         smem[0][k] = 16'sd1000;
         cmem[0][k] = (k == 0) ? 16'sh7FFF : 16'sh0000;
      end
      launch(0, 1'b1);
      for (int k = 0; k < NUM_TAPS; k++) begin
         checks++;
         if (bus.tap_addr !== ADDR_W'(k) || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL tap_walk: tap=%0d busy=%b, required tap=%0d busy=1", bus.tap_addr, bus.busy, k);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.tap_addr !== ADDR_W'(NUM_TAPS - 1)) begin
         failures++;
         $display("FAIL tap_hold: got %0d, required %0d", bus.tap_addr, NUM_TAPS - 1);
      end
      wait_drain();
      checks++;
      if (sb.size() != 0 || bus.out_data !== 16'sd1000) begin
         failures++;
         $display("FAIL impulse: pending=%0d out_data=%0d, required 0 and 1000", sb.size(), bus.out_data);
      end
   endtask

   task automatic test_sat();
      logic [DATA_W-1:0] req;
`ifdef FIR_SAT_EN
      req = 16'h7FFF;
`else
      req = 16'h8000;
`endif
      for (int k = 0; k < NUM_TAPS; k++) begin
         smem[1][k] = 16'sh4000;
         cmem[1][k] = 16'sh4000;
      end
      launch(1, 1'b1);
      wait_drain();
      checks++;
      if (sb.size() != 0 || bus.out_data !== req) begin
         failures++;
         $display("FAIL overflow: pending=%0d out_data=%h, required 0 and %h", sb.size(), bus.out_data, req);
      end
   endtask

   task automatic test_sign();
      for (int k = 0; k < NUM_TAPS; k++) begin
         smem[2][k] = 16'sh8000;
         cmem[2][k] = 16'shFFFF;
      end
      launch(2, 1'b1);
      wait_drain();
      checks++;
      if (sb.size() != 0 || bus.out_data !== 16'sd4) begin
         failures++;
         $display("FAIL sign_ext: pending=%0d out_data=%0d, required 0 and 4", sb.size(), bus.out_data);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         smem[1][k] = DATA_W'($urandom);
         cmem[1][k] = COEFF_W'($urandom);
      end
      launch(1, 1'b1);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.ch_sel = 2'd2;
      @(negedge clk);
      bus.start  = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_window: out_valid=%b busy=%b, required 1 0", bus.out_valid, bus.busy);
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
         smem[2][k] = DATA_W'($urandom);
         cmem[2][k] = COEFF_W'($urandom);
      end
      launch(2, 1'b1);
      wait_drain();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain: pending=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_abort();
      logic [DATA_W-1:0] prev;
      prev = bus.out_data;
      launch(0, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.tap_addr !== 2'd2) begin
         failures++;
         $display("FAIL abort_pos: tap=%0d, required 2", bus.tap_addr);
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_data !== prev) begin
         failures++;
         $display("FAIL abort_run: busy=%b out_data=%h, required 0 %h", bus.busy, bus.out_data, prev);
      end
      repeat (8) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_output: out_valid=%b, required 0", bus.out_valid);
         end
      end
      // abort on the final drain cycle
      launch(1, 1'b0);
      repeat (6) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_last_busy: busy=%b, required 1", bus.busy);
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== prev) begin
         failures++;
         $display("FAIL abort_last: out_valid=%b busy=%b out_data=%h, required 0 0 %h",
                  bus.out_valid, bus.busy, bus.out_data, prev);
      end
   endtask

   task automatic test_channel();
      bus.ch_sel = 2'd3;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL bad_channel: busy=%b, required 0", bus.busy);
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
         smem[1][k] = DATA_W'($urandom_range(0, 2000));
         cmem[1][k] = COEFF_W'($urandom_range(0, 2000));
      end
      bus.abort  = 1'b1;
      bus.start  = 1'b1;
      bus.ch_sel = 2'd1;
      sb.push_back(model(1, cyc));
      @(negedge clk);
      bus.abort  = 1'b0;
      bus.start  = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.act_ch !== 2'd1) begin
         failures++;
         $display("FAIL start_over_abort: busy=%b act_ch=%0d, required 1 1", bus.busy, bus.act_ch);
      end
      wait_drain();
      checks++;
      if (sb.size() != 0 || bus.out_ch !== 2'd1) begin
         failures++;
         $display("FAIL channel_tag: pending=%0d out_ch=%0d, required 0 1", sb.size(), bus.out_ch);
      end
   endtask

   task automatic test_random();
      int ch;
      for (int p = 0; p < 4; p++) begin
         ch = int'($urandom_range(0, NUM_CH - 1));
         for (int k = 0; k < NUM_TAPS; k++) begin
            smem[ch][k] = DATA_W'($urandom);
            cmem[ch][k] = COEFF_W'($urandom);
         end
         launch(ch, 1'b1);
         wait_drain();
         checks++;
         if (sb.size() != 0) begin
            failures++;
            $display("FAIL random_pass%0d: pending=%0d, required 0", p, sb.size());
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_sat();
      test_sign();
      test_back_to_back();
      test_abort();
      test_channel();
      test_random();
      repeat (5) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL final_queue: pending=%0d, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
